// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants and fetch FSM state type for the cpu front end.
//   Opcodes are 4 bits, taken from the top nibble of a 16-bit instruction.
//   NOP_INSTR    : word issued whenever nothing useful can be issued.
//   END_SENTINEL : end-of-program marker in the program image.
package cpu_isa_pkg;

  localparam int unsigned OPCODE_WIDTH = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD              = 4'h0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB              = 4'h1;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND              = 4'h2;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR               = 4'h3;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR              = 4'h4;
  localparam logic [OPCODE_WIDTH-1:0] OP_START_TENSOR_CORE = 4'h5;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD             = 4'h6;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE            = 4'h7;
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP             = 4'h8;
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP              = 4'h9;
  localparam logic [OPCODE_WIDTH-1:0] OP_READ_TENSOR_CORE = 4'hA;

  localparam logic [15:0] NOP_INSTR    = 16'h9000;
  localparam logic [15:0] END_SENTINEL = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_TC,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/program_memory.sv
// Program image storage: DEPTH x INSTR_WIDTH, one synchronous write port,
// one combinational read port. Contents are never reset.
//   clock_in            : write clock
//   write_enable_in     : write strobe
//   write_address_in    : write address
//   write_data_in       : write data
//   read_address_in     : read address
//   read_data_out       : mem[read_address_in], combinational
module program_memory #(
  parameter  int unsigned DEPTH       = 1024,
  parameter  int unsigned INSTR_WIDTH = 16,
  localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                   clock_in,
  input  logic                   write_enable_in,
  input  logic [ADDR_WIDTH-1:0]  write_address_in,
  input  logic [INSTR_WIDTH-1:0] write_data_in,
  input  logic [ADDR_WIDTH-1:0]  read_address_in,
  output logic [INSTR_WIDTH-1:0] read_data_out
);

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock_in) begin
    if (write_enable_in) begin
      mem_q[write_address_in] <= write_data_in;
    end
  end

  assign read_data_out = mem_q[read_address_in];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the program image and issues one word per
// cycle to the cpu, stopping at the end sentinel or the last address, and
// issuing NOPs while a tensor-core operation is in flight.
//   clock_in / reset_in       : clock, synchronous active-high reset
//   start_in                  : begin execution at address 0 (IDLE/HALT only)
//   prog_write_*_in           : program load port (accepted in IDLE/HALT only)
//   tensor_core_done_in       : tensor core finished its operation
//   current_instruction_out   : registered instruction to the cpu
//   pc_out                    : address of the next word to read
//   busy_out / halted_out     : RUN|WAIT_TC / program ended
// Optional feature macro INSTR_FETCH_COUNT_EN adds issued_count_out, a
// saturating count of non-NOP words issued since reset or the last start.
module instruction_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter  int unsigned DEPTH       = 1024,
  parameter  int unsigned INSTR_WIDTH = 16,
  localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   start_in,
  input  logic                   prog_write_enable_in,
  input  logic [ADDR_WIDTH-1:0]  prog_write_address_in,
  input  logic [INSTR_WIDTH-1:0] prog_write_data_in,
  input  logic                   tensor_core_done_in,
  output logic [INSTR_WIDTH-1:0] current_instruction_out,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic                   busy_out,
  output logic                   halted_out
`ifdef INSTR_FETCH_COUNT_EN
  ,
  output logic [31:0]            issued_count_out
`endif
);

  localparam logic [INSTR_WIDTH-1:0] NOP_W  = INSTR_WIDTH'(NOP_INSTR);
  localparam logic [INSTR_WIDTH-1:0] SENT_W = INSTR_WIDTH'(END_SENTINEL);
  localparam logic [ADDR_WIDTH-1:0]  LAST_A = ADDR_WIDTH'(DEPTH - 1);

  fetch_state_t           state_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   busy_q;
  logic                   halted_q;
  logic                   tc_first_q;  // first WAIT_TC cycle: done is stale
  logic [INSTR_WIDTH-1:0] word;
  logic                   mem_we;
  logic                   accept_start;

  // Program loads only while not executing.
  assign mem_we       = prog_write_enable_in && (state_q == IDLE || state_q == HALT);
  assign accept_start = start_in && (state_q == IDLE || state_q == HALT);

  program_memory #(
    .DEPTH       (DEPTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_program_memory (
    .clock_in         (clock_in),
    .write_enable_in  (mem_we),
    .write_address_in (prog_write_address_in),
    .write_data_in    (prog_write_data_in),
    .read_address_in  (pc_q),
    .read_data_out    (word)
  );

  // Fetch FSM with registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= NOP_W;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      tc_first_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          instr_q <= NOP_W;
          if (accept_start) begin
            state_q  <= RUN;
            pc_q     <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        RUN: begin
          if (word == SENT_W) begin
            instr_q  <= NOP_W;
            state_q  <= HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            instr_q <= word;
            // Last address issues its word and stops; pc never wraps.
            if (pc_q == LAST_A) begin
              state_q  <= HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + ADDR_WIDTH'(1);
              if (word[INSTR_WIDTH-1 -: OPCODE_WIDTH] == OP_START_TENSOR_CORE) begin
                state_q    <= WAIT_TC;
                tc_first_q <= 1'b1;
              end
            end
          end
        end
        WAIT_TC: begin
          instr_q    <= NOP_W;
          tc_first_q <= 1'b0;
          if (!tc_first_q && tensor_core_done_in) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef INSTR_FETCH_COUNT_EN
  logic [31:0] count_q;

  // Saturating count of real (non-NOP) words issued.
  always_ff @(posedge clock_in) begin
    if (reset_in || accept_start) begin
      count_q <= '0;
    end else if (state_q == RUN && word != SENT_W && word != NOP_W &&
                 count_q != 32'hFFFF_FFFF) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign issued_count_out = count_q;
`endif

  assign current_instruction_out = instr_q;
  assign pc_out                  = pc_q;
  assign busy_out                = busy_q;
  assign halted_out              = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed program runs with
// literal expectations, plus a cycle-level reference model compared every cycle.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam logic [15:0] NOP  = 16'h9000;
  localparam logic [15:0] SENT = 16'hFFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [15:0]   wdata = '0;
  logic          done = 1'b0;
  logic [15:0]   instr;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
`ifdef INSTR_FETCH_COUNT_EN
  logic [31:0]   cnt;
`endif

  int errors = 0;
  int checks = 0;

  instruction_fetch_unit #(.DEPTH(DEPTH), .INSTR_WIDTH(16)) dut (
    .clock_in                (clk),
    .reset_in                (rst),
    .start_in                (start),
    .prog_write_enable_in    (we),
    .prog_write_address_in   (waddr),
    .prog_write_data_in      (wdata),
    .tensor_core_done_in     (done),
    .current_instruction_out (instr),
    .pc_out                  (pc),
    .busy_out                (busy),
    .halted_out              (halted)
`ifdef INSTR_FETCH_COUNT_EN
    ,
    .issued_count_out        (cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=waiting for tensor core 3=halted.
  logic [15:0] m_mem [DEPTH];
  int          m_mode = 0;
  int          m_pc = 0;
  int          m_age = 0;   // cycles already spent waiting
  logic [15:0] m_out = NOP;
  bit          m_halt = 0;
  bit          m_valid = 0;
  logic [15:0] m_word;

  assign m_word = m_mem[m_pc];

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1;
      m_mode  <= 0;
      m_pc    <= 0;
      m_out   <= NOP;
      m_halt  <= 0;
      m_age   <= 0;
    end else begin
      if (we && (m_mode == 0 || m_mode == 3)) m_mem[waddr] <= wdata;
      case (m_mode)
        0, 3: begin
          m_out <= NOP;
          if (start) begin
            m_mode <= 1;
            m_pc   <= 0;
            m_halt <= 0;
          end
        end
        1: begin
          if (m_word == SENT) begin
            m_out  <= NOP;
            m_mode <= 3;
            m_halt <= 1;
          end else begin
            m_out <= m_word;
            if (m_pc == DEPTH - 1) begin
              m_mode <= 3;
              m_halt <= 1;
            end else begin
              m_pc   <= m_pc + 1;
              m_mode <= (m_word[15:12] == 4'h5) ? 2 : 1;
              m_age  <= 0;
            end
          end
        end
        2: begin
          m_out <= NOP;
          if (m_age >= 1 && done) m_mode <= 1;
          m_age <= m_age + 1;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_instr", 32'(instr), 32'(m_out));
      chk("model_pc", 32'(pc), 32'(m_pc));
      chk("model_busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
      chk("model_halted", 32'(halted), 32'(m_halt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    we = 1'b1; waddr = AW'(a); wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    // Reset state
    tick(); tick();
    chk("reset_instr", 32'(instr), 32'h9000);
    chk("reset_pc", 32'(pc), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_halted", 32'(halted), 0);
    rst = 1'b0;

    // Plain program with sentinel
    load(0, 16'h0012); load(1, 16'h1034); load(2, SENT);
    start_pulse();
    chk("t2_first_cycle_nop", 32'(instr), 32'h9000);
    chk("t2_busy", 32'(busy), 1);
    tick(); chk("t2_w0", 32'(instr), 32'h0012); chk("t2_not_halted", 32'(halted), 0);
    tick(); chk("t2_w1", 32'(instr), 32'h1034);
    tick(); chk("t2_sent_nop", 32'(instr), 32'h9000); chk("t2_halted", 32'(halted), 1);
    tick(); chk("t2_after_nop", 32'(instr), 32'h9000); chk("t2_pc_hold", 32'(pc), 2);

    // Tensor-core wait with done held high (stale done masked)
    load(0, 16'h5000); load(1, 16'h0012); load(2, SENT);
    done = 1'b1;
    start_pulse();
    tick(); chk("t3_tc", 32'(instr), 32'h5000);
    tick(); chk("t3_wait0", 32'(instr), 32'h9000);
    tick(); chk("t3_wait1", 32'(instr), 32'h9000);
    tick(); chk("t3_next", 32'(instr), 32'h0012);
    tick(); chk("t3_halted", 32'(halted), 1);
    done = 1'b0;

    // Tensor-core wait with late done
    start_pulse();
    tick(); chk("t4_tc", 32'(instr), 32'h5000);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("t4_wait_nop", 32'(instr), 32'h9000); chk("t4_wait_busy", 32'(busy), 1);
    end
    done = 1'b1;
    tick(); chk("t4_done_cycle_nop", 32'(instr), 32'h9000);
    done = 1'b0;
    tick(); chk("t4_next", 32'(instr), 32'h0012);
    tick(); chk("t4_halted", 32'(halted), 1);

    // Write during RUN is ignored
    load(0, 16'h0012); load(1, 16'h1034); load(2, SENT);
    start_pulse();
    we = 1'b1; waddr = AW'(1); wdata = 16'hAAAA;
    tick(); we = 1'b0;
    chk("t5_w0", 32'(instr), 32'h0012);
    tick(); chk("t5_w1_kept", 32'(instr), 32'h1034);
    tick(); chk("t5_halted", 32'(halted), 1);
    start_pulse();
    tick(); chk("t5_rerun_w0", 32'(instr), 32'h0012);
    tick(); chk("t5_rerun_w1", 32'(instr), 32'h1034);
    tick();

    // Reset mid-run, memory retained
    start_pulse();
    tick(); chk("t1_running", 32'(instr), 32'h0012);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1_instr", 32'(instr), 32'h9000);
    chk("t1_pc", 32'(pc), 0);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_halted", 32'(halted), 0);
    start_pulse();
    tick(); chk("t1_retained_w0", 32'(instr), 32'h0012);
    tick(); chk("t1_retained_w1", 32'(instr), 32'h1034);
    tick();

    // Full memory without sentinel; start mid-run is ignored
    for (int i = 0; i < DEPTH; i++) load(i, 16'(i));
    start_pulse();
    n = 0;
    while (!halted && n < 1100) begin
      start = (n == 100);
      tick();
      n++;
    end
    start = 1'b0;
    chk("t6_halted_in_time", 32'(halted), 1);
    chk("t6_cycles", 32'(n), 32'(DEPTH));
    chk("t6_last_word", 32'(instr), 32'h03FF);
    chk("t6_pc_last", 32'(pc), 32'(DEPTH - 1));
`ifdef INSTR_FETCH_COUNT_EN
    chk("t6_count", cnt, 32'(DEPTH));
`endif
    tick();
    chk("t6_after_nop", 32'(instr), 32'h9000);
    chk("t6_no_wrap", 32'(pc), 32'(DEPTH - 1));
    chk("t6_still_halted", 32'(halted), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
